// File: rtl/util_watch_dog_ctrl.sv
// Two-stage escalating watchdog: prescaled countdown through RUN -> WARN -> BITE,
// with keyed kicks, a timed reset pulse on second expiry and a sticky config lock.
module util_watch_dog_ctrl #(
    parameter int          CNT_W   = 32,
    parameter int          PRE_W   = 16,
    parameter logic [15:0] KEY     = 16'hA5C3,
    parameter int          RST_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_lock,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic [CNT_W-1:0] cfg_warn_preset,
    input  logic [CNT_W-1:0] cfg_bite_preset,
    input  logic             kick_valid,
    input  logic [15:0]      kick_key,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] count,
    output logic             warn_irq,
    output logic             bite_rst,
    output logic [7:0]       bite_cnt,
    output logic             locked
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WARN = 2'd2,
        S_BITE = 2'd3
    } state_t;

    localparam int LEN_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(RST_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             warn_irq_q, warn_irq_d;
    logic             bite_rst_q, bite_rst_d;
    logic [7:0]       bite_cnt_q, bite_cnt_d;
    logic             locked_q, locked_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [PRE_W-1:0] sh_pre_q, sh_pre_d;
    logic [CNT_W-1:0] sh_warn_q, sh_warn_d;
    logic [CNT_W-1:0] sh_bite_q, sh_bite_d;

    logic en_eff, tick, good_kick, bad_kick, do_bite;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        warn_irq_d = warn_irq_q;
        bite_rst_d = bite_rst_q;
        bite_cnt_d = bite_cnt_q;
        pre_d      = '0;
        len_d      = '0;
        do_bite    = 1'b0;

        locked_d  = locked_q | cfg_lock;
        sh_pre_d  = locked_q ? sh_pre_q  : cfg_prescale;
        sh_warn_d = locked_q ? sh_warn_q : cfg_warn_preset;
        sh_bite_d = locked_q ? sh_bite_q : cfg_bite_preset;

        en_eff    = cfg_en | locked_q;
        tick      = (pre_q == sh_pre_q);
        good_kick = kick_valid && (kick_key == KEY);
        bad_kick  = kick_valid && (kick_key != KEY);

        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (en_eff) begin
                    state_d = S_RUN;
                    count_d = sh_warn_q;
                end
            end
            S_RUN, S_WARN: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (!en_eff) begin
                    state_d    = S_IDLE;
                    count_d    = '0;
                    warn_irq_d = 1'b0;
                    pre_d      = '0;
                end else if (bad_kick) begin
                    do_bite = 1'b1;
                end else if (good_kick) begin
                    state_d    = S_RUN;
                    count_d    = sh_warn_q;
                    warn_irq_d = 1'b0;
                    pre_d      = '0;
                end else if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else if (state_q == S_RUN) begin
                        state_d    = S_WARN;
                        count_d    = sh_bite_q;
                        warn_irq_d = 1'b1;
                    end else begin
                        do_bite = 1'b1;
                    end
                end
            end
            default: begin
                // BITE: the pulse always runs its full length; only rst can cut it short.
                count_d = '0;
                if (len_q == LEN_LAST) begin
                    bite_rst_d = 1'b0;
                    state_d    = en_eff ? S_RUN : S_IDLE;
                    count_d    = en_eff ? sh_warn_q : '0;
                end else begin
                    len_d = len_q + 1'b1;
                end
            end
        endcase

        if (do_bite) begin
            state_d    = S_BITE;
            count_d    = '0;
            warn_irq_d = 1'b0;
            bite_rst_d = 1'b1;
            pre_d      = '0;
            len_d      = '0;
            bite_cnt_d = (bite_cnt_q != 8'hFF) ? bite_cnt_q + 8'd1 : bite_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            warn_irq_q <= 1'b0;
            bite_rst_q <= 1'b0;
            bite_cnt_q <= '0;
            locked_q   <= 1'b0;
            pre_q      <= '0;
            len_q      <= '0;
            sh_pre_q   <= '0;
            sh_warn_q  <= '0;
            sh_bite_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            warn_irq_q <= warn_irq_d;
            bite_rst_q <= bite_rst_d;
            bite_cnt_q <= bite_cnt_d;
            locked_q   <= locked_d;
            pre_q      <= pre_d;
            len_q      <= len_d;
            sh_pre_q   <= sh_pre_d;
            sh_warn_q  <= sh_warn_d;
            sh_bite_q  <= sh_bite_d;
        end
    end

    assign state    = state_q;
    assign count    = count_q;
    assign warn_irq = warn_irq_q;
    assign bite_rst = bite_rst_q;
    assign bite_cnt = bite_cnt_q;
    assign locked   = locked_q;

endmodule
